// File: rtl/count_bus_iface_pkg.sv
// count_pkg: shared encodings for the 8253-style counter channel bus interface.
package count_pkg;
    localparam int CW_W = 16;
    // LSB positions of the control-word fields: SC[7:6], RW[5:4], M[3:1]
    localparam int CW_SC = 6;
    localparam int CW_RW = 4;
    localparam int CW_M = 1;
    typedef enum logic [1:0] {RW_LATCH = 2'b00, RW_LSB = 2'b01, RW_MSB = 2'b10, RW_BOTH = 2'b11} rw_e;
    typedef enum logic [2:0] {MODE0 = 3'd0, MODE1 = 3'd1, MODE2 = 3'd2, MODE3 = 3'd3} mode_e;
    typedef enum logic {PTR_LSB = 1'b0, PTR_MSB = 1'b1} ptr_e;
    // Mode code to one-hot {p1,p2,os}; mode 0 is all zero
    function automatic logic [2:0] mode_onehot(input logic [2:0] m);
        return m == MODE1 ? 3'b100 : m == MODE2 ? 3'b010 : m == MODE3 ? 3'b001 : 3'b000;
    endfunction
endpackage

// File: rtl/count_bus_iface_if.sv
// count_bus_iface_if: CPU bus + counter-side signals of one counter channel.
//   master: drives wr, rd, a, din, count_in; observes read data and mode/load flags
//   slave : the bus interface block itself
interface count_bus_iface_if;
    import count_pkg::*;
    logic            wr;
    logic            rd;
    logic            a;
    logic [7:0]      din;
    logic [CW_W-1:0] count_in;
    logic [7:0]      dout;
    logic            dout_vld;
    logic [CW_W-1:0] init_val;
    logic            plmodif;
    logic            plnif;
    logic            plnact;
    logic            p1;
    logic            p2;
    logic            os;
    modport master (
        output wr, rd, a, din, count_in,
        input  dout, dout_vld, init_val, plmodif, plnif, plnact, p1, p2, os
    );
    modport slave (
        input  wr, rd, a, din, count_in,
        output dout, dout_vld, init_val, plmodif, plnif, plnact, p1, p2, os
    );
endinterface

// File: rtl/count_bus_iface_rdbk_latch.sv
// count_rdbk_latch: counter latch, read-byte pointer and registered read data.
//   clk, reset       : clock, async active-low reset
//   cw_set_i         : accepted non-latch control word (restart read sequence)
//   latch_cmd_i      : accepted latch command
//   plmodif_i, rw_i  : mode-programmed flag and read/load format
//   rd_i             : read strobe already qualified against a concurrent write
//   count_in_i       : live counter value
//   dout_o/dout_vld_o: read data, valid one cycle after rd_i
module count_rdbk_latch
    import count_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            cw_set_i,
    input  logic            latch_cmd_i,
    input  logic            plmodif_i,
    input  rw_e             rw_i,
    input  logic            rd_i,
    input  logic [CW_W-1:0] count_in_i,
    output logic [7:0]      dout_o,
    output logic            dout_vld_o
);
    ptr_e            rptr_q, rptr_d;
    logic            r_msb, rd_ok, hi, last;
    logic            lf_q, lf_d, vld_q, vld_d;
    logic [CW_W-1:0] latch_q, latch_d, src;
    logic [7:0]      dout_q, dout_d;

    always_ff @(posedge clk or negedge reset)
        if (!reset) rptr_q <= PTR_LSB;
        else rptr_q <= rptr_d;

    always_comb
        rptr_d = cw_set_i ? PTR_LSB :
                 (rd_ok && rw_i == RW_BOTH) ? (rptr_q == PTR_LSB ? PTR_MSB : PTR_LSB) : rptr_q;

    always_comb r_msb = rptr_q == PTR_MSB;

    always_comb begin
        rd_ok = rd_i && plmodif_i;
        src = lf_q ? latch_q : count_in_i;
        hi = rw_i == RW_MSB || (rw_i == RW_BOTH && r_msb);
        // the latch is released once the last byte of the format has been read
        last = rw_i != RW_BOTH || r_msb;
        latch_d = (latch_cmd_i && plmodif_i && !lf_q) ? count_in_i : latch_q;
        lf_d = cw_set_i ? 1'b0 : (latch_cmd_i && plmodif_i) ? 1'b1 : (rd_ok && last) ? 1'b0 : lf_q;
        dout_d = !rd_i ? dout_q : !plmodif_i ? 8'h00 : hi ? src[15:8] : src[7:0];
        vld_d = rd_i;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            latch_q <= '0;
            lf_q <= 1'b0;
            dout_q <= 8'h00;
            vld_q <= 1'b0;
        end else begin
            latch_q <= latch_d;
            lf_q <= lf_d;
            dout_q <= dout_d;
            vld_q <= vld_d;
        end

    assign dout_o = dout_q;
    assign dout_vld_o = vld_q;
endmodule

// File: rtl/count_bus_iface.sv
// count_bus_iface: CPU-side control/count interface for one 8253-style counter channel.
//   clk   : system clock, rising edge
//   reset : async active-low reset
//   bus   : slave side of count_bus_iface_if (writes, reads, count_in in;
//           init_val, mode bits, plmodif/plnif/plnact and read data out)
module count_bus_iface
    import count_pkg::*;
#(
    parameter logic [1:0] CH_SEL = 2'b00
) (
    input logic             clk,
    input logic             reset,
    count_bus_iface_if.slave bus
);
    ptr_e            wptr_q, wptr_d;
    rw_e             rw_q, rw_d;
    logic [2:0]      mode_q, mode_d;
    logic            plmodif_q, plmodif_d, plnif_q, plnif_d, plnact_q, plnact_d;
    logic [CW_W-1:0] init_q, init_d;
    logic            cw_ok, cw_set, latch_cmd, cnt_wr, load_done, rd_en, w_msb;
    logic            unused_rsvd;

    assign unused_rsvd = bus.din[0];
    // mode codes 4..7 have din[3] set and void the whole word
    assign cw_ok = bus.wr && bus.a && bus.din[CW_SC+:2] == CH_SEL && !bus.din[CW_M+2];
    assign latch_cmd = cw_ok && bus.din[CW_RW+:2] == RW_LATCH;
    assign cw_set = cw_ok && bus.din[CW_RW+:2] != RW_LATCH;
    assign cnt_wr = bus.wr && !bus.a && plmodif_q;
    assign rd_en = bus.rd && !bus.wr;

    always_ff @(posedge clk or negedge reset)
        if (!reset) wptr_q <= PTR_LSB;
        else wptr_q <= wptr_d;

    always_comb
        wptr_d = cw_set ? PTR_LSB :
                 (cnt_wr && rw_q == RW_BOTH) ? (wptr_q == PTR_LSB ? PTR_MSB : PTR_LSB) : wptr_q;

    always_comb w_msb = wptr_q == PTR_MSB;

    always_comb begin
        // rw_q is never RW_LATCH once plmodif is set, so any other format completes in one byte
        load_done = cnt_wr && (rw_q != RW_BOTH || w_msb);
        rw_d = cw_set ? rw_e'(bus.din[CW_RW+:2]) : rw_q;
        mode_d = cw_set ? mode_onehot(bus.din[CW_M+:3]) : mode_q;
        plmodif_d = plmodif_q || cw_set;
        plnif_d = cw_set ? 1'b0 : (plnif_q || load_done);
        plnact_d = load_done && plnif_q;
        init_d = !cnt_wr ? init_q :
                 rw_q == RW_LSB ? {8'h00, bus.din} :
                 rw_q == RW_MSB ? {bus.din, 8'h00} :
                 w_msb ? {bus.din, init_q[7:0]} : {init_q[15:8], bus.din};
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            rw_q <= RW_LATCH;
            mode_q <= 3'b000;
            plmodif_q <= 1'b0;
            plnif_q <= 1'b0;
            plnact_q <= 1'b0;
            init_q <= '0;
        end else begin
            rw_q <= rw_d;
            mode_q <= mode_d;
            plmodif_q <= plmodif_d;
            plnif_q <= plnif_d;
            plnact_q <= plnact_d;
            init_q <= init_d;
        end

    count_rdbk_latch u_rdbk (
        .clk(clk),
        .reset(reset),
        .cw_set_i(cw_set),
        .latch_cmd_i(latch_cmd),
        .plmodif_i(plmodif_q),
        .rw_i(rw_q),
        .rd_i(rd_en),
        .count_in_i(bus.count_in),
        .dout_o(bus.dout),
        .dout_vld_o(bus.dout_vld)
    );

    assign {bus.p1, bus.p2, bus.os} = mode_q;
    assign bus.plmodif = plmodif_q;
    assign bus.plnif = plnif_q;
    assign bus.plnact = plnact_q;
    assign bus.init_val = init_q;
endmodule

// File: tb/tb_count_bus_iface.sv
// tb_count_bus_iface: randomized and directed self-checking bench for count_bus_iface.
module tb_count_bus_iface;
    import count_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int errors = 0;
    int checks = 0;

    count_bus_iface_if bus();
    count_bus_iface #(.CH_SEL(2'b00)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // transaction-level model of the channel
    logic [1:0]  m_rw;
    logic [2:0]  m_bits;
    bit          m_mod, m_nif, m_act, m_lat;
    logic [15:0] m_init, m_lval;
    int          m_wb, m_rb;
    bit          exp_vld;
    logic [7:0]  exp_dout;

    function automatic logic [2:0] bits_of(input logic [1:0] code);
        logic [2:0] tbl [4] = '{3'b000, 3'b100, 3'b010, 3'b001};
        return tbl[code];
    endfunction

    function automatic void m_reset();
        m_rw = 2'd0; m_bits = 3'd0; m_mod = 0; m_nif = 0; m_act = 0;
        m_lat = 0; m_init = 16'h0; m_lval = 16'h0; m_wb = 0; m_rb = 0;
    endfunction

    function automatic void m_write(input logic aa, input logic [7:0] d);
        bit done = 0;
        m_act = 0;
        if (aa) begin
            if (d[7:6] != 2'b00 || d[3]) return;
            if (d[5:4] == 2'b00) begin
                if (!m_lat && m_mod) begin m_lat = 1; m_lval = bus.count_in; end
            end else begin
                m_rw = d[5:4]; m_bits = bits_of(d[2:1]); m_mod = 1; m_nif = 0;
                m_wb = 0; m_rb = 0; m_lat = 0;
            end
        end else if (m_mod) begin
            if (m_rw == 2'd1) begin m_init = {8'h00, d}; done = 1; end
            else if (m_rw == 2'd2) begin m_init = {d, 8'h00}; done = 1; end
            else if (m_wb == 0) begin m_init[7:0] = d; m_wb = 1; end
            else begin m_init[15:8] = d; m_wb = 0; done = 1; end
            if (done) begin m_act = m_nif; m_nif = 1; end
        end
    endfunction

    function automatic logic [7:0] m_read();
        logic [15:0] v;
        int byte_no;
        if (!m_mod) return 8'h00;
        v = m_lat ? m_lval : bus.count_in;
        byte_no = m_rw == 2'd1 ? 0 : m_rw == 2'd2 ? 1 : m_rb;
        if (m_rw == 2'd3) m_rb = 1 - m_rb;
        if (m_rw != 2'd3 || byte_no == 1) m_lat = 0;
        return byte_no == 1 ? v[15:8] : v[7:0];
    endfunction

    function automatic logic [21:0] exp_state();
        return {m_bits, m_mod, m_nif, m_act, m_init};
    endfunction

    function automatic logic [21:0] act_state();
        return {bus.p1, bus.p2, bus.os, bus.plmodif, bus.plnif, bus.plnact, bus.init_val};
    endfunction

    // one clock of stimulus, called just after a falling edge; returns after the next one
    task automatic cyc(input logic w, input logic r, input logic aa, input logic [7:0] d);
        bus.wr = w; bus.rd = r; bus.a = aa; bus.din = d;
        m_act = 0;
        exp_vld = r && !w;
        if (w) m_write(aa, d);
        else if (r) exp_dout = m_read();
        @(negedge clk);
        bus.wr = 1'b0; bus.rd = 1'b0;
    endtask

    task automatic test_reset();
        m_reset();
        @(negedge clk); @(negedge clk);
        checks++;
        if (act_state() !== 22'h0 || bus.dout_vld !== 1'b0 || bus.dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_state got=%h/%b/%h exp=0", act_state(), bus.dout_vld, bus.dout);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_two_byte();
        bus.count_in = 16'h0;
        cyc(1, 0, 1, 8'h36);
        cyc(1, 0, 0, 8'h34);
        checks++;
        if (bus.plnif !== 1'b0) begin errors++; $display("FAIL two_byte_partial plnif got=%b exp=0", bus.plnif); end
        cyc(1, 0, 0, 8'h12);
        checks++;
        if (act_state() !== {3'b001, 1'b1, 1'b1, 1'b0, 16'h1234}) begin
            errors++; $display("FAIL two_byte_load got=%h exp=%h", act_state(), {3'b001, 3'b110, 16'h1234});
        end
    endtask

    task automatic test_reload();
        cyc(1, 0, 0, 8'hCD);
        checks++;
        if (bus.plnact !== 1'b0 || bus.plnif !== 1'b1) begin
            errors++; $display("FAIL reload_lsb plnact/plnif got=%b%b exp=01", bus.plnact, bus.plnif);
        end
        cyc(1, 0, 0, 8'hAB);
        checks++;
        if (bus.init_val !== 16'hABCD || bus.plnact !== 1'b1 || bus.plnif !== 1'b1) begin
            errors++; $display("FAIL reload_msb got=%h act=%b nif=%b exp=abcd 1 1", bus.init_val, bus.plnact, bus.plnif);
        end
        cyc(0, 0, 0, 8'h00);
        checks++;
        if (bus.plnact !== 1'b0 || bus.plnif !== 1'b1) begin
            errors++; $display("FAIL reload_pulse_width act=%b nif=%b exp=0 1", bus.plnact, bus.plnif);
        end
    endtask

    task automatic test_latch();
        logic [7:0] exp_seq [4] = '{8'h3C, 8'h5A, 8'h00, 8'h00};
        logic [7:0] exp_seq2 [2] = '{8'h34, 8'h12};
        bus.count_in = 16'h5A3C;
        cyc(1, 0, 1, 8'h06);
        bus.count_in = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 8'h00);
            checks++;
            if (bus.dout_vld !== 1'b1 || bus.dout !== exp_seq[i]) begin
                errors++; $display("FAIL latch_read%0d got=%b/%h exp=1/%h", i, bus.dout_vld, bus.dout, exp_seq[i]);
            end
        end
        cyc(0, 0, 0, 8'h00);
        checks++;
        if (bus.dout_vld !== 1'b0) begin errors++; $display("FAIL latch_vld_pulse got=%b exp=0", bus.dout_vld); end
        bus.count_in = 16'h1234;
        cyc(1, 0, 1, 8'h06);
        bus.count_in = 16'hABCD;
        cyc(1, 0, 1, 8'h06);
        bus.count_in = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 0, 8'h00);
            checks++;
            if (bus.dout !== exp_seq2[i]) begin
                errors++; $display("FAIL relatch_ignored%0d got=%h exp=%h", i, bus.dout, exp_seq2[i]);
            end
        end
    endtask

    task automatic test_single_byte();
        cyc(1, 0, 1, 8'h12);
        checks++;
        if (bus.plnif !== 1'b0 || {bus.p1, bus.p2, bus.os} !== 3'b100) begin
            errors++; $display("FAIL ctrl12 nif=%b bits=%b exp=0 100", bus.plnif, {bus.p1, bus.p2, bus.os});
        end
        cyc(1, 0, 0, 8'hFF);
        checks++;
        if (bus.init_val !== 16'h00FF || bus.plnif !== 1'b1) begin
            errors++; $display("FAIL lsb_only got=%h nif=%b exp=00ff 1", bus.init_val, bus.plnif);
        end
        cyc(1, 0, 1, 8'h24);
        checks++;
        if (bus.plnif !== 1'b0 || {bus.p1, bus.p2, bus.os} !== 3'b010) begin
            errors++; $display("FAIL ctrl24 nif=%b bits=%b exp=0 010", bus.plnif, {bus.p1, bus.p2, bus.os});
        end
        cyc(1, 0, 0, 8'h80);
        checks++;
        if (bus.init_val !== 16'h8000 || bus.plnif !== 1'b1 || bus.plnact !== 1'b0) begin
            errors++; $display("FAIL msb_only got=%h nif=%b act=%b exp=8000 1 0", bus.init_val, bus.plnif, bus.plnact);
        end
    endtask

    task automatic test_ignored();
        logic [7:0] bad [2] = '{8'h3A, 8'h76};
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 1, bad[i]);
            checks++;
            if (act_state() !== {3'b010, 3'b110, 16'h8000}) begin
                errors++; $display("FAIL ignored_ctrl_%h got=%h exp=%h", bad[i], act_state(), {3'b010, 3'b110, 16'h8000});
            end
        end
        cyc(1, 1, 0, 8'h55);
        checks++;
        if (bus.dout_vld !== 1'b0 || bus.init_val !== 16'h5500 || bus.plnact !== 1'b1) begin
            errors++; $display("FAIL wr_rd_same_cycle vld=%b init=%h act=%b exp=0 5500 1", bus.dout_vld, bus.init_val, bus.plnact);
        end
    endtask

    task automatic test_async_reset();
        cyc(1, 0, 1, 8'h36);
        cyc(1, 0, 0, 8'h34);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (act_state() !== 22'h0 || bus.dout_vld !== 1'b0) begin
            errors++; $display("FAIL async_reset got=%h vld=%b exp=0", act_state(), bus.dout_vld);
        end
        @(negedge clk);
        reset = 1'b1;
        m_reset();
        cyc(1, 0, 0, 8'h12);
        checks++;
        if (bus.plnif !== 1'b0 || bus.init_val !== 16'h0 || bus.plmodif !== 1'b0) begin
            errors++; $display("FAIL write_after_reset nif=%b init=%h mod=%b exp=0 0 0", bus.plnif, bus.init_val, bus.plmodif);
        end
        cyc(0, 1, 0, 8'h00);
        checks++;
        if (bus.dout_vld !== 1'b1 || bus.dout !== 8'h00) begin
            errors++; $display("FAIL read_unprogrammed got=%b/%h exp=1/00", bus.dout_vld, bus.dout);
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        int op;
        for (int n = 0; n < 400; n++) begin
            bus.count_in = 16'($urandom());
            d = 8'($urandom());
            op = $urandom_range(0, 9);
            if (op <= 2) begin
                if ($urandom_range(0, 3) != 0) d[7:6] = 2'b00;
                if ($urandom_range(0, 3) != 0) d[3] = 1'b0;
                if (op == 2) d[5:4] = 2'b00;
                cyc(1, 0, 1, d);
            end else if (op <= 5) cyc(1, 0, 0, d);
            else if (op <= 8) cyc(0, 1, 0, d);
            else cyc(1, 1, 0, d);
            checks++;
            if (act_state() !== exp_state()) begin
                errors++; $display("FAIL rand_state n=%0d got=%h exp=%h", n, act_state(), exp_state());
            end
            checks++;
            if (bus.dout_vld !== exp_vld || (exp_vld && bus.dout !== exp_dout)) begin
                errors++; $display("FAIL rand_read n=%0d got=%b/%h exp=%b/%h", n, bus.dout_vld, bus.dout, exp_vld, exp_dout);
            end
        end
    endtask

    initial begin
        bus.wr = 1'b0; bus.rd = 1'b0; bus.a = 1'b0; bus.din = 8'h00; bus.count_in = 16'h0;
        test_reset();
        test_two_byte();
        test_reload();
        test_latch();
        test_single_byte();
        test_ignored();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end
endmodule
